// File: rtl/mintrk_pkg.sv
// Shared definitions for the running-minimum tracker: word width, default index width, FSM states.
package mintrk_pkg;
    localparam int WORD_W    = 32;
    localparam int IDX_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/cmp_u32_lt.sv
// Purely combinational unsigned 32-bit less-than comparator.
module cmp_u32_lt (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt
);
    assign lt = (a < b);
endmodule

// File: rtl/running_min_tracker.sv
// Streaming frame minimum tracker with saturating beat counter and overflow flag.
// Define MINTRK_ARGMIN_EN to add the first-occurrence index register and out_idx port.
module running_min_tracker
    import mintrk_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_min,
`ifdef MINTRK_ARGMIN_EN
    output logic [IDX_W-1:0]  out_idx,
`endif
    output logic              out_ovf
);
    localparam logic [IDX_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [WORD_W-1:0] min_q, nmin;
    logic [IDX_W-1:0]  cnt, ncnt;
    logic              ovf_q, novf;
    logic              lt, take, sat;
`ifdef MINTRK_ARGMIN_EN
    logic [IDX_W-1:0]  idx_q, nidx;
`endif

    cmp_u32_lt u_cmp (
        .a  (in_data),
        .b  (min_q),
        .lt (lt)
    );

    // Candidate next values for an accepted beat; strict compare keeps the earliest index on ties.
    always_comb begin
        take = in_valid && in_ready;
        sat  = (cnt == CNT_MAX);
        if (state == IDLE) begin
            nmin = in_data;
            ncnt = IDX_W'(1);
            novf = 1'b0;
`ifdef MINTRK_ARGMIN_EN
            nidx = '0;
`endif
        end else begin
            nmin = lt ? in_data : min_q;
            ncnt = sat ? cnt : cnt + 1'b1;
            novf = ovf_q | sat;
`ifdef MINTRK_ARGMIN_EN
            nidx = lt ? cnt : idx_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_min   <= '0;
            out_ovf   <= 1'b0;
            min_q     <= '0;
            cnt       <= '0;
            ovf_q     <= 1'b0;
`ifdef MINTRK_ARGMIN_EN
            idx_q     <= '0;
            out_idx   <= '0;
`endif
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (take) begin
                        min_q <= nmin;
                        cnt   <= ncnt;
                        ovf_q <= novf;
`ifdef MINTRK_ARGMIN_EN
                        idx_q <= nidx;
`endif
                        if (in_last) begin
                            // Result registers only update here, so they hold between frames.
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_min   <= nmin;
                            out_ovf   <= novf;
`ifdef MINTRK_ARGMIN_EN
                            out_idx   <= nidx;
`endif
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_running_min_tracker.sv
// Directed table-driven bench for running_min_tracker (default IDX_W and IDX_W=2 instances).
module tb_running_min_tracker;
    logic        clk = 1'b0;
    logic        rst;
    logic        v0, l0, r0, v1, l1, r1;
    logic [31:0] d0, d1;
    logic        ir0, ov0, ovf0, ir1, ov1, ovf1;
    logic [31:0] min0, min1;
`ifdef MINTRK_ARGMIN_EN
    logic [7:0]  idx0;
    logic [1:0]  idx1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    running_min_tracker #(.IDX_W(8)) u0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(ir0), .in_data(d0), .in_last(l0),
        .out_valid(ov0), .out_ready(r0), .out_min(min0),
`ifdef MINTRK_ARGMIN_EN
        .out_idx(idx0),
`endif
        .out_ovf(ovf0)
    );

    running_min_tracker #(.IDX_W(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_data(d1), .in_last(l1),
        .out_valid(ov1), .out_ready(r1), .out_min(min1),
`ifdef MINTRK_ARGMIN_EN
        .out_idx(idx1),
`endif
        .out_ovf(ovf1)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_min;
        logic [7:0]  e_idx;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [31:0] d, logic l, logic ordy,
                                logic e_ir, logic e_ov, logic [31:0] e_min,
                                logic [7:0] e_idx, logic e_ovf);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.ordy = ordy;
        t.e_ir = e_ir; t.e_ov = e_ov; t.e_min = e_min; t.e_idx = e_idx; t.e_ovf = e_ovf;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string nm, input logic e_ir, input logic e_ov,
                        input logic [31:0] e_min, input logic [7:0] e_idx, input logic e_ovf);
        chk({nm, ".in_ready"},  {31'd0, ir0},  {31'd0, e_ir});
        chk({nm, ".out_valid"}, {31'd0, ov0},  {31'd0, e_ov});
        chk({nm, ".out_min"},   min0,          e_min);
        chk({nm, ".out_ovf"},   {31'd0, ovf0}, {31'd0, e_ovf});
`ifdef MINTRK_ARGMIN_EN
        chk({nm, ".out_idx"},   {24'd0, idx0}, {24'd0, e_idx});
`else
        if (e_idx == 8'hFF) $display("unexpected index sentinel in %s", nm);
`endif
    endtask

    initial begin
        rst = 1'b1;
        v0 = 0; d0 = 0; l0 = 0; r0 = 0;
        v1 = 0; d1 = 0; l1 = 0; r1 = 0;

        // frame 7,3,9,3: first occurrence of 3 wins
        tbl.push_back(mk(1, 32'd7, 0, 1, 1, 0, 32'd0, 0, 0));
        tbl.push_back(mk(1, 32'd3, 0, 1, 1, 0, 32'd0, 0, 0));
        tbl.push_back(mk(1, 32'd9, 0, 1, 1, 0, 32'd0, 0, 0));
        tbl.push_back(mk(1, 32'd3, 1, 1, 0, 1, 32'd3, 1, 0));
        tbl.push_back(mk(0, 32'd0, 0, 1, 1, 0, 32'd3, 1, 0));
        // single-beat all-ones frame, then MSB-only difference
        tbl.push_back(mk(1, 32'hFFFFFFFF, 1, 1, 0, 1, 32'hFFFFFFFF, 0, 0));
        tbl.push_back(mk(0, 32'd0,        0, 1, 1, 0, 32'hFFFFFFFF, 0, 0));
        tbl.push_back(mk(1, 32'h80000000, 0, 1, 1, 0, 32'hFFFFFFFF, 0, 0));
        tbl.push_back(mk(1, 32'h7FFFFFFF, 1, 0, 0, 1, 32'h7FFFFFFF, 1, 0));
        // back-pressure: 5 cycles in HOLD with beats offered, none accepted
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 32'd0, 1, 0, 0, 1, 32'h7FFFFFFF, 1, 0));
        // release: back to IDLE, offered beat must not bypass into a new frame
        tbl.push_back(mk(1, 32'd0, 1, 1, 1, 0, 32'h7FFFFFFF, 1, 0));
        // gaps inside a frame: 4, _, _, 2(last)
        tbl.push_back(mk(1, 32'd4, 0, 1, 1, 0, 32'h7FFFFFFF, 1, 0));
        tbl.push_back(mk(0, 32'd0, 1, 1, 1, 0, 32'h7FFFFFFF, 1, 0));
        tbl.push_back(mk(0, 32'd1, 1, 1, 1, 0, 32'h7FFFFFFF, 1, 0));
        tbl.push_back(mk(1, 32'd2, 1, 1, 0, 1, 32'd2, 1, 0));
        tbl.push_back(mk(0, 32'd0, 0, 1, 1, 0, 32'd2, 1, 0));
        // tie keeps the earlier index
        tbl.push_back(mk(1, 32'd5, 0, 1, 1, 0, 32'd2, 1, 0));
        tbl.push_back(mk(1, 32'd5, 1, 1, 0, 1, 32'd5, 0, 0));
        tbl.push_back(mk(0, 32'd0, 0, 1, 1, 0, 32'd5, 0, 0));

        step();
        step();
        chk0("reset", 1, 0, 32'd0, 0, 0);
        chk("reset.u1_out_valid", {31'd0, ov1}, 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            v0 = tbl[i].v; d0 = tbl[i].d; l0 = tbl[i].l; r0 = tbl[i].ordy;
            step();
            chk0($sformatf("row%0d", i), tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_min,
                 tbl[i].e_idx, tbl[i].e_ovf);
        end

        // reset mid-frame after 5, 1 discards the frame
        v0 = 1; d0 = 32'd5; l0 = 0; r0 = 1; step();
        d0 = 32'd1; step();
        chk0("pre_rst", 1, 0, 32'd5, 0, 0);
        rst = 1'b1; d0 = 32'd0; l0 = 1; step();
        chk0("mid_rst", 1, 0, 32'd0, 0, 0);
        rst = 1'b0; d0 = 32'd2; l0 = 1; step();
        chk0("post_rst", 0, 1, 32'd2, 0, 0);
        v0 = 0; l0 = 0; step();
        chk0("post_rst_rel", 1, 0, 32'd2, 0, 0);

        // IDX_W=2: six beats 9..4 overflow the counter
        r1 = 1;
        for (int k = 0; k < 6; k++) begin
            v1 = 1; d1 = 32'(9 - k); l1 = (k == 5);
            step();
            if (k < 5) chk($sformatf("ovf_seq.ov%0d", k), {31'd0, ov1}, 32'd0);
        end
        chk("ovf.out_valid", {31'd0, ov1},  32'd1);
        chk("ovf.out_min",   min1,          32'd4);
        chk("ovf.out_ovf",   {31'd0, ovf1}, 32'd1);
        chk("ovf.in_ready",  {31'd0, ir1},  32'd0);
`ifdef MINTRK_ARGMIN_EN
        chk("ovf.out_idx",   {30'd0, idx1}, 32'd3);
`endif
        v1 = 0; l1 = 0; step();
        v1 = 1; d1 = 32'd1; l1 = 1; step();
        chk("ovf_clr.out_ovf", {31'd0, ovf1}, 32'd0);
        chk("ovf_clr.out_min", min1,          32'd1);
`ifdef MINTRK_ARGMIN_EN
        chk("ovf_clr.out_idx", {30'd0, idx1}, 32'd0);
`endif
        v1 = 0; l1 = 0; step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
